// File: rtl/ledtest_pkg.sv
// Shared types and default constants for the LED-test button debouncer.
package ledtest_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_e;

endpackage

// File: rtl/ledtest_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit level; resets to 0.
module ledtest_sync
  import ledtest_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/ledtest_btn_debounce.sv
// Button debouncer: synchronizer, 4-state debounce FSM, optional edge pulses and press counter.
// Edge/count logic is built only when LEDTEST_DEBOUNCE_EDGE_EN is defined.
module ledtest_btn_debounce
  import ledtest_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic        count_clr,
  output logic        btn_level,
  output logic        btn_rise,
  output logic        btn_fall,
  output logic [15:0] press_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Entry into WAIT already counts one sample, so commit when the held count is one short.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            w_sync_q;
  logic            w_commit_hi;
  logic            w_commit_lo;
  deb_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_level;

  ledtest_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw),
    .q    (w_sync_q)
  );

  assign w_commit_hi = (r_state == WAIT_HI) && w_sync_q && (r_cnt == CntLast);
  assign w_commit_lo = (r_state == WAIT_LO) && !w_sync_q && (r_cnt == CntLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          if (w_sync_q) begin
            r_state <= WAIT_HI;
            r_cnt   <= CntW'(1);
          end
        end
        WAIT_HI: begin
          if (!w_sync_q) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (w_commit_hi) begin
            r_state <= STABLE_HI;
            r_level <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!w_sync_q) begin
            r_state <= WAIT_LO;
            r_cnt   <= CntW'(1);
          end
        end
        WAIT_LO: begin
          if (w_sync_q) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (w_commit_lo) begin
            r_state <= STABLE_LO;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level = r_level;

`ifdef LEDTEST_DEBOUNCE_EDGE_EN
  logic        r_rise;
  logic        r_fall;
  logic [15:0] r_press_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_rise <= w_commit_hi;
      r_fall <= w_commit_lo;
      // A clear coinciding with a rise still counts that rise.
      if (count_clr) begin
        r_press_count <= w_commit_hi ? 16'd1 : 16'd0;
      end else if (w_commit_hi) begin
        r_press_count <= r_press_count + 16'd1;
      end
    end
  end

  assign btn_rise    = r_rise;
  assign btn_fall    = r_fall;
  assign press_count = r_press_count;
`else
  logic w_unused_count_clr;
  assign w_unused_count_clr = count_clr;

  assign btn_rise    = 1'b0;
  assign btn_fall    = 1'b0;
  assign press_count = 16'd0;
`endif

endmodule

// File: doc/ledtest_btn_debounce.md
LEDTEST_BTN_DEBOUNCE -- requirements
Module: ledtest_btn_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on btn_raw; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable samples required to accept a level change; legal range 2..2^20.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port btn_raw, input, 1, asynchronous mechanical button/switch level.
REQ-006 Port count_clr, input, 1, synchronous clear of press_count.
REQ-007 Port btn_level, output, 1, registered debounced level; drives the PIO in_port.
REQ-008 Port btn_rise, output, 1, one-cycle pulse on an accepted 0->1 change.
REQ-009 Port btn_fall, output, 1, one-cycle pulse on an accepted 1->0 change.
REQ-010 Port press_count, output, 16, count of accepted rises.

Function
REQ-011 btn_raw SHALL pass through a SYNC_STAGES-deep flop chain; the FSM SHALL sample only the chain output (sync_q).
REQ-012 FSM states SHALL be STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-013 STABLE_LO with sync_q=1 SHALL go to WAIT_HI with counter=1; STABLE_HI with sync_q=0 SHALL go to WAIT_LO with counter=1.
REQ-014 In WAIT_x, a sample matching the candidate level SHALL increment the counter; a sample reaching DEBOUNCE_CYCLES SHALL commit: go to STABLE_x, update btn_level, and clear the counter.
REQ-015 In WAIT_x, a sample not matching the candidate SHALL return the FSM to the previous STABLE state with counter=0 and btn_level unchanged.
REQ-016 Latency: with btn_raw held, btn_level SHALL change at rising edge N = SYNC_STAGES + DEBOUNCE_CYCLES, counting the first edge that samples the new btn_raw as edge 1.
REQ-017 Any glitch with a sync_q run shorter than DEBOUNCE_CYCLES samples SHALL leave btn_level, btn_rise, btn_fall and press_count unchanged.
REQ-018 btn_rise/btn_fall SHALL be registered, assert high for exactly one cycle, and assert on the same edge that btn_level changes.
REQ-019 press_count SHALL increment by 1 on each btn_rise and wrap from 0xFFFF to 0x0000.
REQ-020 count_clr with no rise SHALL set press_count to 0; count_clr together with a rise SHALL set it to 1.
REQ-021 The counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); the counter SHALL never exceed DEBOUNCE_CYCLES.

Reset
REQ-022 reset SHALL force the sync chain to 0, FSM=STABLE_LO, counter=0, btn_level=0, btn_rise=0, btn_fall=0, press_count=0 on the next edge.
REQ-023 Reset asserted mid-WAIT SHALL abandon the pending change; if btn_raw is high after release, btn_level SHALL rise only after full REQ-016 latency, and a btn_rise SHALL be generated.

Configuration
REQ-024 Macro LEDTEST_DEBOUNCE_EDGE_EN defined: btn_rise, btn_fall and press_count SHALL behave per REQ-018..020.
REQ-025 Macro LEDTEST_DEBOUNCE_EDGE_EN undefined: btn_rise, btn_fall and press_count SHALL be tied constant 0, no edge/count logic synthesized, and count_clr ignored; btn_level behaviour unchanged.

Structure
REQ-026 Shared package ledtest_pkg SHALL hold the FSM state enum and the default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-027 The synchronizer SHALL be a separate sub-module ledtest_sync (parameter STAGES, reset value 0); everything else SHALL live in ledtest_btn_debounce.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_EN defined unless noted)
REQ-028 Reset, then btn_raw 0->1 held -> btn_level=1 and btn_rise=1 (one cycle) at edge 6, press_count=1.
REQ-029 btn_raw high for 3 cycles, then low -> btn_level stays 0, no pulses, press_count stays 0.
REQ-030 Accepted high, then btn_raw low held -> btn_fall pulse and btn_level=0 at edge 6 after the change; press_count unchanged.
REQ-031 press_count preloaded to 0xFFFF by 65535 presses, one more press -> press_count=0x0000; count_clr on the same edge as a rise -> press_count=1.
REQ-032 reset asserted at WAIT_HI counter=2 with btn_raw held high -> outputs 0; after release btn_level rises 6 edges later.
REQ-033 EDGE_EN undefined, REQ-028 stimulus -> btn_level identical, btn_rise/btn_fall/press_count constant 0.
